// File: rtl/div_f_arbiter.sv
// div_f_arbiter: round-robin sharing of one fractional divider among NREQ requesters
module div_f_arbiter #(
    parameter int WIDTH     = 32,
    parameter int RES_WIDTH = 32,
    parameter int NREQ      = 4,
    parameter int IDX_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [RES_WIDTH-1:0]  rsp_res,
    output logic                  rsp_dbz,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_busy,
    input  logic [RES_WIDTH-1:0]  div_res,
    output logic                  active
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, RESP} state_t;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d, owner_q, owner_d, win;
    logic [WIDTH-1:0]     dvd_q, dvd_d, dvs_q, dvs_d, sel_dvd, sel_dvs;
    logic [RES_WIDTH-1:0] res_q, res_d;
    logic                 dbz_q, dbz_d, found;

    // first valid requester at or after rr_q (wrapping) wins, with its operands
    always_comb begin
        win = '0;
        found = 1'b0;
        sel_dvd = '0;
        sel_dvs = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[IDX_W'((int'(rr_q) + k) % NREQ)]) begin
                found = 1'b1;
                win = IDX_W'((int'(rr_q) + k) % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win) begin
                sel_dvd = req_dividend[i*WIDTH +: WIDTH];
                sel_dvs = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // next-state and datapath update; a zero divisor skips the divider entirely
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        owner_d = owner_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        res_d = res_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = win;
                    rr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    dvd_d = sel_dvd;
                    dvs_d = sel_dvs;
                    if (sel_dvs == '0) begin
                        res_d = '1;
                        dbz_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = div_busy ? RUN : WAIT_BUSY;
            RUN: begin
                if (!div_busy) begin
                    res_d = div_res;
                    dbz_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP:      state_d = rsp_ready[owner_q] ? IDLE : RESP;
            default:   state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any in-flight job
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q <= '0;
            owner_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            res_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            owner_q <= owner_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            res_q <= res_d;
            dbz_q <= dbz_d;
        end
    end

    assign req_ready    = (state_q == IDLE && rst && found) ? ONE << win : '0;
    assign rsp_valid    = (state_q == RESP) ? ONE << owner_q : '0;
    assign rsp_res      = res_q;
    assign rsp_dbz      = (state_q == RESP) && dbz_q;
    assign div_start    = state_q == ISSUE;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign active       = state_q != IDLE;
endmodule
